// File: rtl/restoring_divider_pkg.sv
// Processor-wide constants shared by the arithmetic sequencers.
// Holds the divider FSM state encoding and the default operand width,
// which the Booth multiply path also uses.
package restoring_divider_pkg;

  localparam int DIV_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'b00,
    DIV_SHIFT = 2'b01,
    DIV_TEST  = 2'b10,
    DIV_DONE  = 2'b11
  } div_state_t;

endpackage

// File: rtl/divider_datapath.sv
// A/Q/M datapath of the restoring divider.
// The controller drives the strobes below. The datapath returns the sign of
// the trial subtraction A - M so the controller can choose between restore
// and accept.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   i_load             capture dividend/divisor, clear A
//   i_load_zero        divide-by-zero result write (all-ones quotient)
//   i_shift            {A,Q} <<= 1
//   i_test             apply trial-subtract outcome to A and Q[0]
//   i_accept           with i_test: keep the difference (quotient bit 1)
//   i_write            with i_test: latch final quotient/remainder
//   i_dividend         dividend operand
//   i_divisor          divisor operand
//   o_diff_neg         sign bit of A - {0,M}
//   o_quotient         registered quotient result
//   o_remainder        registered remainder result
//   o_div_by_zero      registered divide-by-zero flag
module divider_datapath
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_load_zero,
  input  logic             i_shift,
  input  logic             i_test,
  input  logic             i_accept,
  input  logic             i_write,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_diff_neg,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_a_next;
  logic [WIDTH-1:0] w_q_next;

  // After a shift A < 2*M, so bit WIDTH of the WIDTH+1 bit difference is set
  // exactly when A < M.
  assign w_diff     = r_a - {1'b0, r_m};
  assign o_diff_neg = w_diff[WIDTH];
  assign w_a_next   = i_accept ? w_diff : r_a;
  assign w_q_next   = {r_q[WIDTH-1:1], i_accept};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a           <= '0;
      r_q           <= '0;
      r_m           <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      if (i_load) begin
        r_a <= '0;
        r_q <= i_dividend;
        r_m <= i_divisor;
      end else if (i_shift) begin
        {r_a, r_q} <= {r_a[WIDTH-1:0], r_q, 1'b0};
      end else if (i_test) begin
        r_a <= w_a_next;
        r_q <= w_q_next;
      end

      // The final write uses the post-test values so the result is ready in DONE.
      if (i_load_zero) begin
        r_quotient    <= '1;
        r_remainder   <= i_dividend;
        r_div_by_zero <= 1'b1;
      end else if (i_write) begin
        r_quotient    <= w_q_next;
        r_remainder   <= w_a_next[WIDTH-1:0];
        r_div_by_zero <= 1'b0;
      end
    end
  end

  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_div_by_zero;

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider with a start/busy/done handshake.
// Each quotient bit takes a SHIFT cycle followed by a TEST cycle.
// A zero divisor skips straight to DONE with the quotient set to all ones,
// the remainder set to the dividend, and div_by_zero raised.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        request, sampled only in IDLE
//   dividend     unsigned dividend, captured on accepted start
//   divisor      unsigned divisor, captured on accepted start
//   busy         high in SHIFT/TEST
//   done         one-cycle pulse in DONE
//   quotient     registered quotient
//   remainder    registered remainder
//   div_by_zero  registered divide-by-zero flag
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int SC_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(WIDTH - 1);

  div_state_t      r_state;
  div_state_t      w_next_state;
  logic [SC_W-1:0] r_sc;

  logic w_divisor_zero;
  logic w_sc_zero;
  logic w_diff_neg;
  logic w_load;
  logic w_load_zero;
  logic w_shift;
  logic w_test;
  logic w_accept;
  logic w_write;

  assign w_divisor_zero = (divisor == '0);
  assign w_sc_zero      = (r_sc == '0);

  // State register and iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DIV_IDLE;
      r_sc    <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_sc <= SC_LAST;
      end else if (w_test && !w_sc_zero) begin
        r_sc <= r_sc - SC_W'(1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      DIV_IDLE: begin
        if (start) begin
          w_next_state = w_divisor_zero ? DIV_DONE : DIV_SHIFT;
        end
      end
      DIV_SHIFT: w_next_state = DIV_TEST;
      DIV_TEST:  w_next_state = w_sc_zero ? DIV_DONE : DIV_SHIFT;
      DIV_DONE:  w_next_state = DIV_IDLE;
      default:   w_next_state = DIV_IDLE;
    endcase
  end

  // Output decode: Moore handshake plus datapath strobes
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    w_load      = 1'b0;
    w_load_zero = 1'b0;
    w_shift     = 1'b0;
    w_test      = 1'b0;
    w_accept    = 1'b0;
    w_write     = 1'b0;
    case (r_state)
      DIV_IDLE: begin
        w_load      = start && !w_divisor_zero;
        w_load_zero = start && w_divisor_zero;
      end
      DIV_SHIFT: begin
        busy    = 1'b1;
        w_shift = 1'b1;
      end
      DIV_TEST: begin
        busy     = 1'b1;
        w_test   = 1'b1;
        w_accept = !w_diff_neg;
        w_write  = w_sc_zero;
      end
      DIV_DONE: done = 1'b1;
      default: ;
    endcase
  end

  divider_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk           (clk),
    .rst           (rst),
    .i_load        (w_load),
    .i_load_zero   (w_load_zero),
    .i_shift       (w_shift),
    .i_test        (w_test),
    .i_accept      (w_accept),
    .i_write       (w_write),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
    .o_diff_neg    (w_diff_neg),
    .o_quotient    (quotient),
    .o_remainder   (remainder),
    .o_div_by_zero (div_by_zero)
  );

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Sequential unsigned restoring divider for the small processor: computes quotient and remainder of dividend / divisor.
- Serves as the division counterpart of the Booth multiply sequence.
- Self-contained FSM plus A/Q/M datapath, with a start/busy/done handshake, so the top-level controller only issues start and waits for done.
- Each iteration is a two-state pair: shift, then trial-subtract/restore.

Parameters:
- WIDTH, 4, operand, quotient and remainder width in bits (WIDTH >= 2).

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  unsigned dividend; captured on accepted start.
- divisor  input  WIDTH  unsigned divisor; captured on accepted start.
- busy  output  1  high in SHIFT and TEST states.
- done  output  1  one-cycle pulse in DONE state.
- quotient  output  WIDTH  registered result, held until the next result is written.
- remainder  output  WIDTH  registered result, held until the next result is written.
- div_by_zero  output  1  registered flag, written together with quotient/remainder.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, SC=0, A=0, Q=0, M=0; quotient=0, remainder=0, div_by_zero=0, done=0, busy=0. Reset overrides all activity, including mid-operation; an aborted operation writes no result.
- Internal registers:
  - A: WIDTH+1 bits, partial remainder with sign bit.
  - Q: WIDTH bits, dividend/quotient.
  - M: WIDTH bits, divisor.
  - SC: clog2(WIDTH) bits, iteration counter.
- State encoding: IDLE=2'b00, SHIFT=2'b01, TEST=2'b10, DONE=2'b11.
- IDLE:
  - start=0: stay in IDLE.
  - start=1 and divisor!=0: A<=0, Q<=dividend, M<=divisor, SC<=WIDTH-1, go to SHIFT.
  - start=1 and divisor==0: quotient<={WIDTH{1}}, remainder<=dividend, div_by_zero<=1, go to DONE.
- SHIFT: {A,Q} <= {A,Q} << 1 (Q[0] becomes 0); go to TEST unconditionally.
- TEST:
  - diff = A - {1'b0,M}, computed WIDTH+1 bits wide.
  - diff[WIDTH]=1 (negative): A unchanged (restore), Q[0]<=0.
  - Otherwise: A<=diff, Q[0]<=1.
  - SC==0: write quotient<=new Q and remainder<=new A[WIDTH-1:0], div_by_zero<=0, go to DONE.
  - Else: SC<=SC-1, go to SHIFT.
- DONE: done=1 for exactly this cycle; go to IDLE unconditionally. start in DONE is ignored and not queued.
- start while busy (SHIFT/TEST) is ignored; dividend/divisor changes after capture have no effect.
- Latency, with start high in cycle 0:
  - Nonzero divisor: done high in cycle 2*WIDTH+1 (cycle 9 for WIDTH=4). Earliest next accepted start is cycle 2*WIDTH+2.
  - Zero divisor: done high in cycle 1.
- busy and done are decoded from state (Moore). quotient, remainder and div_by_zero are registers, stable from the done cycle until the next result write.
- Results satisfy dividend = quotient*divisor + remainder and remainder < divisor for every nonzero divisor, including dividend < divisor (quotient=0) and dividend=max.

Decomposition:
- Shared package (processor-wide):
  - state encoding constants DIV_IDLE/DIV_SHIFT/DIV_TEST/DIV_DONE;
  - the default WIDTH constant, shared with the multiply path.
- Sub-module divider_datapath: holds A/Q/M, the shift and trial-subtract logic, and the result registers. It is driven by load/shift/test/write strobes from the FSM in restoring_divider and returns the diff sign bit, mirroring the processor's controller/datapath split.

Test Plan:
- Reset, then dividend=13, divisor=3, start in cycle 0 -> busy cycles 1-8; done=1 only in cycle 9; quotient=4, remainder=1, div_by_zero=0.
- dividend=15, divisor=1 -> quotient=15, remainder=0; dividend=2, divisor=7 -> quotient=0, remainder=2; both with done in cycle 9.
- dividend=9, divisor=0 -> done in cycle 1; quotient=4'hF, remainder=9, div_by_zero=1, busy never high. A subsequent 6/3 clears div_by_zero with quotient=2, remainder=0.
- Start 13/3, then pulse start with 8/2 in cycle 4 and again in the DONE cycle -> both ignored; result stays 4/1; only one done pulse.
- Start 13/3 and assert rst in cycle 4 -> busy=0 from cycle 5; no done; quotient/remainder=0. Then start 7/2 -> quotient=3, remainder=1 after 9 cycles.
- Exhaustive sweep of all 16x15 nonzero WIDTH=4 pairs, back-to-back starts issued the cycle after done -> every result matches the reference model; done-to-next-done spacing is 10 cycles.
